// File: rtl/rtc_resp_pkg.sv
// rtl/rtc_resp_pkg.sv - register map, reset values, bus FSM encoding and month length for the RTC responder
package rtc_resp_pkg;

  localparam logic [7:0] ADDR_CTRL = 8'h00;
  localparam logic [7:0] ADDR_SEC  = 8'h21;
  localparam logic [7:0] ADDR_MIN  = 8'h22;
  localparam logic [7:0] ADDR_HOUR = 8'h23;
  localparam logic [7:0] ADDR_DAY  = 8'h24;
  localparam logic [7:0] ADDR_MON  = 8'h25;
  localparam logic [7:0] ADDR_YEAR = 8'h26;

  typedef struct packed {
    logic [7:0] year;
    logic [7:0] mon;
    logic [7:0] day;
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
  } rtc_time_t;

  localparam rtc_time_t RST_TIME = '{year: 8'h00, mon: 8'h01, day: 8'h01,
                                     hour: 8'h00, min: 8'h00, sec: 8'h00};
  localparam logic [7:0] RST_CTRL = 8'h00;
  localparam logic [7:0] RST_ADDR = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR_LATCH,
    ST_DATA
  } bus_state_t;

  // Returns the last valid day of the month in BCD.
  function automatic logic [7:0] month_len(input logic [7:0] mon, input logic leap);
    case (mon)
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      8'h02:                      return leap ? 8'h29 : 8'h28;
      default:                    return 8'h31;
    endcase
  endfunction

endpackage

// File: rtl/rtc_bus_responder_if.sv
// rtl/rtc_bus_responder_if.sv - multiplexed cs/rd/wr/ad RTC bus between controller (master) and responder (slave)
interface rtc_bus_responder_if;
  logic       cs;
  logic       rd;
  logic       wr;
  logic       ad;
  logic [7:0] din;
  logic [7:0] dout;
  logic       dout_oe;

  modport master (output cs, rd, wr, ad, din, input dout, dout_oe);
  modport slave  (input cs, rd, wr, ad, din, output dout, dout_oe);
endinterface

// File: rtl/rtc_bcd_timekeeper.sv
// rtl/rtc_bcd_timekeeper.sv - combinational next-second BCD cascade (sec..year, leap year, 12/24 h)
module rtc_bcd_timekeeper
  import rtc_resp_pkg::*;
(
  input  rtc_time_t cur,
  input  logic      twelve,
  output rtc_time_t nxt
);

  // Out-of-range or non-BCD values roll straight to the field minimum and carry.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo,
                                         input logic [7:0] hi);
    if (v[3:0] > 4'd9 || v >= hi || v < lo) return {1'b1, lo};
    if (v[3:0] == 4'd9) return {1'b0, v[7:4] + 4'd1, 4'd0};
    return {1'b0, v + 8'd1};
  endfunction

  logic       leap;
  logic [8:0] s_inc, m_inc, h24_inc, h12_inc, h_inc, d_inc, mo_inc, y_inc;
  logic       c_s, c_m, c_h, c_d, c_mo;

  assign leap = cur.year[4] ? (cur.year[3:0] == 4'd2 || cur.year[3:0] == 4'd6)
                            : (cur.year[3:0] == 4'd0 || cur.year[3:0] == 4'd4 ||
                               cur.year[3:0] == 4'd8);

  always_comb begin
    s_inc   = bcd_inc(cur.sec,  8'h00, 8'h59);
    m_inc   = bcd_inc(cur.min,  8'h00, 8'h59);
    h24_inc = bcd_inc(cur.hour, 8'h00, 8'h23);
    d_inc   = bcd_inc(cur.day,  8'h01, month_len(cur.mon, leap));
    mo_inc  = bcd_inc(cur.mon,  8'h01, 8'h12);
    y_inc   = bcd_inc(cur.year, 8'h00, 8'h99);

    // 12 h: 11 -> 12 flips PM (day carries at 11 PM), 12 -> 01 keeps PM.
    if (cur.hour[4:0] == 5'h11) begin
      h12_inc = {cur.hour[7], ~cur.hour[7], 7'h12};
    end else if (cur.hour[4:0] == 5'h12) begin
      h12_inc = {1'b0, cur.hour[7], 7'h01};
    end else begin
      h12_inc    = bcd_inc({3'b000, cur.hour[4:0]}, 8'h01, 8'h12);
      h12_inc[7] = cur.hour[7];
    end
    h_inc = twelve ? h12_inc : h24_inc;

    c_s  = s_inc[8];
    c_m  = c_s & m_inc[8];
    c_h  = c_m & h_inc[8];
    c_d  = c_h & d_inc[8];
    c_mo = c_d & mo_inc[8];

    nxt      = cur;
    nxt.sec  = s_inc[7:0];
    nxt.min  = c_s  ? m_inc[7:0]  : cur.min;
    nxt.hour = c_m  ? h_inc[7:0]  : cur.hour;
    nxt.day  = c_h  ? d_inc[7:0]  : cur.day;
    nxt.mon  = c_d  ? mo_inc[7:0] : cur.mon;
    nxt.year = c_mo ? y_inc[7:0]  : cur.year;
  end

endmodule

// File: rtl/rtc_bus_responder.sv
// rtl/rtc_bus_responder.sv - RTC bus responder: bus FSM, address latch, BCD register file, read mux
// Optional 12-hour mode enabled by defining RTC_RESP_TWELVE_HOUR_EN.
module rtc_bus_responder
  import rtc_resp_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  rtc_bus_responder_if.slave  bus
);

  bus_state_t        state;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        ctrl;
  rtc_time_t         tm, tm_next;
  logic              wr_q, conflict_q, pend;
  logic              wr_event, addr_wr, data_wr, time_wr, read_cond, apply_tick, twelve;
  logic [7:0]        rd_data, hour_wdata;

`ifdef RTC_RESP_TWELVE_HOUR_EN
  assign twelve     = ctrl[4];
  assign hour_wdata = bus.din;
`else
  assign twelve     = 1'b0;
  assign hour_wdata = {1'b0, bus.din[6:0]};
`endif

  // A wr rise that follows a cycle with rd and wr both low is part of an illegal cycle.
  assign wr_event   = !bus.cs && !wr_q && bus.wr && !conflict_q;
  assign addr_wr    = wr_event && !bus.ad;
  assign data_wr    = wr_event && bus.ad;
  assign time_wr    = data_wr && (addr >= ADDR_W'(ADDR_SEC)) && (addr <= ADDR_W'(ADDR_YEAR));
  assign read_cond  = !bus.cs && !bus.rd && bus.ad && bus.wr;
  assign apply_tick = (tick || pend) && !time_wr;

  rtc_bcd_timekeeper u_timekeeper (
    .cur    (tm),
    .twelve (twelve),
    .nxt    (tm_next)
  );

  always_comb begin
    rd_data = 8'h00;
    case (addr)
      ADDR_W'(ADDR_CTRL): rd_data = ctrl;
      ADDR_W'(ADDR_SEC):  rd_data = tm.sec;
      ADDR_W'(ADDR_MIN):  rd_data = tm.min;
      ADDR_W'(ADDR_HOUR): rd_data = tm.hour;
      ADDR_W'(ADDR_DAY):  rd_data = tm.day;
      ADDR_W'(ADDR_MON):  rd_data = tm.mon;
      ADDR_W'(ADDR_YEAR): rd_data = tm.year;
      default:            rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else if (bus.cs) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:       if (addr_wr) state <= ST_ADDR_LATCH;
        ST_ADDR_LATCH: if (data_wr || read_cond) state <= ST_DATA;
        ST_DATA:       if (bus.rd && bus.wr) state <= ST_IDLE;
        default:       state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr        <= ADDR_W'(RST_ADDR);
      ctrl        <= RST_CTRL;
      tm          <= RST_TIME;
      wr_q        <= 1'b1;
      conflict_q  <= 1'b0;
      pend        <= 1'b0;
      bus.dout    <= 8'h00;
      bus.dout_oe <= 1'b0;
    end else begin
      wr_q       <= bus.wr;
      conflict_q <= !bus.rd && !bus.wr;
      // A tick colliding with a time write is replayed on the next cycle.
      pend       <= time_wr ? (pend | tick) : (pend & tick);
      if (addr_wr) addr <= ADDR_W'(bus.din);
      if (apply_tick) tm <= tm_next;
      if (data_wr) begin
        case (addr)
          ADDR_W'(ADDR_CTRL): ctrl    <= bus.din;
          ADDR_W'(ADDR_SEC):  tm.sec  <= bus.din;
          ADDR_W'(ADDR_MIN):  tm.min  <= bus.din;
          ADDR_W'(ADDR_HOUR): tm.hour <= hour_wdata;
          ADDR_W'(ADDR_DAY):  tm.day  <= bus.din;
          ADDR_W'(ADDR_MON):  tm.mon  <= bus.din;
          ADDR_W'(ADDR_YEAR): tm.year <= bus.din;
          default: ;
        endcase
      end
      bus.dout_oe <= read_cond;
      bus.dout    <= read_cond ? rd_data : 8'h00;
    end
  end

endmodule

// File: doc/rtc_bus_responder.md
# rtc_bus_responder

Behavioural responder for the multiplexed cs/rd/wr/ad real-time-clock bus. It sits on the device side of the bus that the RTC controller drives. The block decodes address and data phases, holds a BCD register file, and returns register contents on reads. An internal timekeeper advances seconds through years on each 1 Hz tick. It is the on-chip stand-in for the external RTC, used for bring-up and for closed-loop verification of the controller.

## Interface
Parameters:
- ADDR_W, 8, width of the latched register address.

Ports:
- clk  in  1  system clock, shared with the controller; no synchronisers.
- reset  in  1  asynchronous, active-low reset.
- cs  in  1  chip select, active low.
- rd  in  1  read strobe, active low.
- wr  in  1  write strobe, active low.
- ad  in  1  phase select: 0 = address phase, 1 = data phase.
- din  in  8  data from the controller, bit 7 = fkda … bit 0 = fkdh.
- tick  in  1  one-cycle 1 Hz strobe.
- dout  out  8  read data, bit 7 maps to lrda.
- dout_oe  out  1  read-data drive enable, active high.

## Operation
- **Register map.** All time registers are BCD.
  - 0x00 control: bit 4 = 12-hour mode, other bits R/W scratch.
  - 0x21 seconds, 0x22 minutes, 0x23 hours, 0x24 day, 0x25 month, 0x26 year.
  - Hours register in 12-hour mode: bit 7 = PM, bits 4:0 = 01–12.
- **Write cycle.** A write event is `cs=0`, `wr` registered low last cycle and high now (wr rising edge).
  - If `ad=0`, `din` is latched as the address.
  - If `ad=1`, `din` is written to the register at the latched address.
- **Unmapped addresses.** Writes are ignored. Reads return 0x00.
- **Read cycle.** While `cs=0`, `rd=0` and `ad=1`, `dout_oe=1` and `dout` shows the live content of the addressed register.
- **Bus FSM states.**
  - IDLE goes to ADDR_LATCH on an address write event.
  - ADDR_LATCH goes to DATA on the next data write or read; both paths return to IDLE.
  - `cs=1` in any state returns the FSM to IDLE. The latched address is retained, so consecutive data accesses hit the same address.
- **Strobe conflict.** `rd` and `wr` low together is illegal. `dout_oe` is held 0 and no write occurs.
- **Timekeeper, advanced on `tick`.**
  - Seconds 59 → 00 carries to minutes; minutes 59 → 00 carries to hours.
  - Hours, 24 h: 23 → 00. Hours, 12 h: 11 → 12 toggles PM, 12 → 01.
  - Day rolls at month length: 30 for 04/06/09/11; for 02, 29 when BCD year is divisible by 4, else 28; 31 otherwise.
  - Month 12 → 01 carries to year. Year 99 → 00.
- **Tick colliding with a data write to any time register.** The write wins. The tick is held pending and applied on the following cycle to the updated values.
- **Illegal BCD written.** A value such as 0x6A is stored as written. The next tick rolls that field to its minimum and carries.
- **Reset values.**
  - Registers: 00:00:00, day 01, month 01, year 00, control 0x00, address 0x00.
  - Outputs: `dout=0x00`, `dout_oe=0`. FSM in IDLE, pending tick cleared.
- **Reset asserted mid-access.** All of the above take effect immediately (asynchronous). A write in flight is lost.

## Timing
- Write data is visible in the register one cycle after the clock edge that detects the `wr` rising edge.
- `dout_oe` rises one cycle after `cs=0, rd=0, ad=1` is first sampled. It falls one cycle after `rd=1` or `cs=1` is sampled.
- While `dout_oe=1`, `dout` is registered and tracks a tick-driven update with one cycle of latency.
- A tick updates all cascaded fields in the same cycle (one-cycle latency from `tick`). A pending tick adds one cycle.
- The minimum legal strobe-low width is 1 cycle.

## Configuration
- **`RTC_RESP_TWELVE_HOUR_EN` defined:** control bit 4 selects 12-hour mode with the PM flag in hours bit 7.
- **Undefined:**
  - Control bit 4 remains R/W scratch but has no effect; hours always count 00–23.
  - Hours bit 7 is forced to 0 on write.

## Structure
- **Package `rtc_resp_pkg`** holds:
  - register address constants (`ADDR_CTRL`, `ADDR_SEC` … `ADDR_YEAR`);
  - reset values;
  - the bus FSM state encoding;
  - the month-length function.
- **Sub-module `rtc_bcd_timekeeper`** is natural. It contains the tick cascade, the BCD increment, the leap-year check and the 12/24-hour logic. The top level contains the bus FSM, the address latch, the register file and read muxing.

## Test plan
- Address write 0x21, data write 0x45, read → `dout=0x45` with `dout_oe=1` one cycle after rd is sampled low.
- Set 23:59:59 on 28/02/23 and pulse `tick` → 00:00:00 on 01/03/23.
- Set 28/02/24 23:59:59 and pulse `tick` → 29/02/24 00:00:00. A second day of ticks gives 01/03/24.
- With the macro defined and control 0x10, set hours 0x11 at 59:59 and pulse `tick` → hours 0x92 (PM, 12).
- Write seconds 0x30 in the same cycle as `tick` → 0x30, then 0x31 next cycle. Read of unmapped address 0x50 → 0x00.
- Drop `reset` during an active read → `dout_oe=0` and `dout=0x00` immediately; time registers back to reset values.
